// File: rtl/mfp_sevenseg_scan_n.sv
// ---------------------------------------------------------------------------
// mfp_sevenseg_scan_n
//   N-digit multiplexed seven-segment display driver (common-anode boards).
//   Scans the digits one at a time, inserts a few all-off clocks after every
//   digit switch to suppress ghosting, and double-buffers the displayed data
//   so a software write never shows up halfway through a frame.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   wr_en       load strobe for data_in / dp_in / digit_en (and blink_mask)
//   data_in     hex nibble per digit, digit i = data_in[4i+3:4i]
//   dp_in       decimal point per digit (1 = lit)
//   digit_en    digit enable (0 = digit dark)
//   blink_mask  per-digit blink select (only with SEVENSEG_BLINK_EN)
//   seg         {CA..CG} = segments {a..g}
//   dp          decimal point
//   an          anode enables, an[0] = rightmost digit
//   frame_done  one-clock pulse after the scan wraps back to digit 0
//
// Build option
//   SEVENSEG_BLINK_EN  adds blink_mask and a frame-based blink phase
// ---------------------------------------------------------------------------
module mfp_sevenseg_scan_n #(
  parameter int N_DIGITS     = 8,
  parameter int CLK_HZ       = 50000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [4*N_DIGITS-1:0]   data_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     digit_en,
`ifdef SEVENSEG_BLINK_EN
  input  logic [N_DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int RAW_DIV  = CLK_HZ / (REFRESH_HZ * N_DIGITS);
  localparam int TICK_DIV = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W    = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYCLES);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [BLK_W-1:0]      blank_cnt;
  logic                  tick;
  logic                  wrap;

  logic [4*N_DIGITS-1:0] pend_data, act_data;
  logic [N_DIGITS-1:0]   pend_dp, act_dp;
  logic [N_DIGITS-1:0]   pend_en, act_en;
  logic                  blink_dark;

  logic [3:0]            nib;
  logic                  lit;
  logic [N_DIGITS-1:0]   an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // Segment pattern {a..g}, active-high.
  function automatic logic [6:0] hexdec(input logic [3:0] v);
    case (v)
      4'h0:    hexdec = 7'b1111110;
      4'h1:    hexdec = 7'b0110000;
      4'h2:    hexdec = 7'b1101101;
      4'h3:    hexdec = 7'b1111001;
      4'h4:    hexdec = 7'b0110011;
      4'h5:    hexdec = 7'b1011011;
      4'h6:    hexdec = 7'b1011111;
      4'h7:    hexdec = 7'b1110000;
      4'h8:    hexdec = 7'b1111111;
      4'h9:    hexdec = 7'b1111011;
      4'hA:    hexdec = 7'b1110111;
      4'hB:    hexdec = 7'b0011111;
      4'hC:    hexdec = 7'b1001110;
      4'hD:    hexdec = 7'b0111101;
      4'hE:    hexdec = 7'b1001111;
      default: hexdec = 7'b1000111;
    endcase
  endfunction

  assign tick = (cnt == CNT_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  // Prescaler and digit scan; each digit switch reloads the blanking counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      blank_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + 1'b1;
      frame_done <= wrap;
      if (tick) begin
        idx       <= wrap ? '0 : idx + 1'b1;
        blank_cnt <= BLK_LOAD;
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

  // Double buffer: active copy only changes at a frame boundary. A write
  // landing on the boundary clock goes straight into the active copy so it
  // is not lost behind the older pending value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data <= '0;
      pend_dp   <= '0;
      pend_en   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
      act_en    <= '0;
    end else begin
      if (wr_en) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
        pend_en   <= digit_en;
      end
      if (wrap) begin
        act_data <= wr_en ? data_in  : pend_data;
        act_dp   <= wr_en ? dp_in    : pend_dp;
        act_en   <= wr_en ? digit_en : pend_en;
      end
    end
  end

`ifdef SEVENSEG_BLINK_EN
  localparam int FR_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLINK_FRAMES - 1);

  logic [N_DIGITS-1:0] pend_blink, act_blink;
  logic [FR_W-1:0]     frame_cnt;
  logic                blink_phase;

  // Blink mask rides the same double buffer; phase flips every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_blink  <= '0;
      act_blink   <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (wr_en) pend_blink <= blink_mask;
      if (wrap) begin
        act_blink <= wr_en ? blink_mask : pend_blink;
        if (frame_cnt == FR_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

  assign blink_dark = blink_phase && act_blink[idx];
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = (BLINK_FRAMES != 0);
  assign blink_dark       = 1'b0;
`endif

  // Active-high view of the next output state for the current scan position.
  always_comb begin
    nib     = act_data[{idx, 2'b00} +: 4];
    lit     = (blank_cnt == '0) && act_en[idx] && !blink_dark;
    an_nxt  = '0;
    seg_nxt = '0;
    dp_nxt  = 1'b0;
    if (lit) begin
      an_nxt  = N_DIGITS'(1) << idx;
      seg_nxt = hexdec(nib);
      dp_nxt  = act_dp[idx];
    end
  end

  // Registered pins with board polarity applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {N_DIGITS{POL}};
      seg <= {7{POL}};
      dp  <= POL;
    end else begin
      an  <= an_nxt ^ {N_DIGITS{POL}};
      seg <= seg_nxt ^ {7{POL}};
      dp  <= dp_nxt ^ POL;
    end
  end

endmodule

// File: tb/tb_mfp_sevenseg_scan_n.sv
// ---------------------------------------------------------------------------
// tb_mfp_sevenseg_scan_n
//   Directed bench for the seven-segment scanner: 4 digits, 10 clocks per
//   digit slot, 2 blank clocks, active-low pins.
// ---------------------------------------------------------------------------
module tb_mfp_sevenseg_scan_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int          total = 0;
  int          bad   = 0;
  logic [3:0]  enVal;
  logic [3:0]  dpVal;

  // Hand-written segment table {a..g}, active-high.
  localparam logic [6:0] HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  mfp_sevenseg_scan_n #(
    .N_DIGITS    (4),
    .CLK_HZ      (4000),
    .REFRESH_HZ  (100),
    .BLANK_CYCLES(2),
    .ACTIVE_LOW  (1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
`ifdef SEVENSEG_BLINK_EN
    .blink_mask(4'b0000),
`endif
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [15:0] data);
    wr_en = wr;
    if (wr) begin
      data_in  = data;
      digit_en = enVal;
      dp_in    = dpVal;
    end
  endtask

  // Expected {an, seg, dp, frame_done} j clocks after a wrap edge.
  function automatic logic [12:0] expectedAt(input logic [15:0] d, input logic [3:0] en,
                                             input logic [3:0] dpm, input int j);
    int         dig;
    int         r;
    logic       lit;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    dig = (j - 1) / 10;
    r   = (j - 1) % 10;
    lit = (r >= 2) && en[dig];
    a   = lit ? ~(4'b0001 << dig) : 4'hF;
    s   = lit ? ~HEX[d[4*dig +: 4]] : 7'h7F;
    p   = lit ? ~dpm[dig] : 1'b1;
    return {a, s, p, (j == 40)};
  endfunction

  task automatic checkFrame(input string name, input logic [15:0] d, input logic [3:0] en,
                            input logic [3:0] dpm, input int nCyc,
                            input int wrA, input logic [15:0] dA,
                            input int wrB, input logic [15:0] dB);
    for (int j = 1; j <= nCyc; j++) begin
      @(negedge clk);
      checkOutput($sformatf("%s_c%0d", name, j), 32'({an, seg, dp, frame_done}),
                  32'(expectedAt(d, en, dpm, j)));
      if (j == wrA)      applyStimulus(1'b1, dA);
      else if (j == wrB) applyStimulus(1'b1, dB);
      else               applyStimulus(1'b0, 16'h0000);
    end
  endtask

  task automatic waitFrameDone(input string name, input int limit, input int expCycles);
    int k    = 0;
    bit seen = 1'b0;
    while (!seen && k < limit) begin
      @(negedge clk);
      k++;
      applyStimulus(1'b0, 16'h0000);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checkOutput({name, "_seen"}, 32'(seen), 32'd1);
    checkOutput({name, "_latency"}, 32'(k), 32'(expCycles));
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    data_in  = 16'h0000;
    dp_in    = 4'h0;
    digit_en = 4'h0;
    enVal    = 4'hF;
    dpVal    = 4'b0100;

    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("reset_c%0d", i), 32'({an, seg, dp, frame_done}),
                  32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    end

    reset = 1'b0;
    applyStimulus(1'b1, 16'h3210);
    waitFrameDone("boot", 100, 40);

    checkFrame("f1", 16'h3210, 4'hF, 4'b0100, 40, -1, 16'h0, -1, 16'h0);
    checkFrame("f2", 16'h3210, 4'hF, 4'b0100, 40, 15, 16'hAAAA, 30, 16'hBBBB);
    checkFrame("f3", 16'hBBBB, 4'hF, 4'b0100, 40, 39, 16'hFFFF, -1, 16'h0);

    enVal = 4'b0101;
    dpVal = 4'b0000;
    checkFrame("f4", 16'hFFFF, 4'hF, 4'b0100, 40, 20, 16'h5678, -1, 16'h0);
    checkFrame("f5", 16'h5678, 4'b0101, 4'b0000, 40, -1, 16'h0, -1, 16'h0);
    checkFrame("f6", 16'h5678, 4'b0101, 4'b0000, 25, -1, 16'h0, -1, 16'h0);

    reset = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_c%0d", i), 32'({an, seg, dp, frame_done}),
                  32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    end

    reset = 1'b0;
    enVal = 4'hF;
    dpVal = 4'b0001;
    applyStimulus(1'b1, 16'h4321);
    waitFrameDone("restart", 100, 40);
    checkFrame("f7", 16'h4321, 4'hF, 4'b0001, 40, -1, 16'h0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
